fcl_servo_pwm_slave: RTL and testbench
======================================

Name: fcl_servo_pwm_slave

Overview:
Bus slave that sits directly downstream of the UART bus master on the shared 32-bit strobe/ack bus. It decodes a 256-byte address window. It holds per-channel servo pulse-width registers in microseconds. It generates glitch-free 50 Hz servo PWM on NUM_CHANNELS outputs.

Parameters:
INPUT_CLOCK_SPEED, 50000000, sys_clk frequency in Hz; must be an integer multiple of 1000000.
NUM_CHANNELS, 8, number of PWM outputs (1..16).
BASE_ADDR, 32'h0000_1000, window base; decode on bus_addr_in[31:8].
PWM_PERIOD_US, 20000, frame length in microseconds.
ACK_LATENCY, 2, sys_clk cycles from accepted strobe to bus_ack (1..15).
MIN_WIDTH_US, 500, lower clamp for nonzero widths.
MAX_WIDTH_US, 2500, upper clamp.
FAILSAFE_FRAMES, 50, frames without a channel write before failsafe; used only with FCL_SERVO_FAILSAFE_EN.

Ports:
sys_clk  in  1  system clock
_reset  in  1  asynchronous active-low reset
bus_addr_in  in  32  byte address from master
bus_data_in  in  32  write data from master
bus_read  in  1  one-cycle read strobe
bus_write  in  1  one-cycle write strobe
bus_data_out  out  32  read data; nonzero only in the bus_ack cycle (OR-muxable)
bus_ack  out  1  one-cycle acknowledge
pwm_out  out  NUM_CHANNELS  servo pulse outputs
frame_pulse  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (asynchronous, _reset low): all outputs 0. CTRL=0. All width and shadow registers 0. Counters 0. FSM in IDLE.
- Register map (offset = bus_addr_in[7:0]):
  - 0x00 CTRL, R/W: bit0 = global enable; other bits read 0.
  - 0x04 STATUS, RO: [15:0] frame count, saturating at 16'hFFFF; [16] failsafe active.
  - 0x10+4*n WIDTHn, R/W: [15:0] pulse width in us.
  - Other in-window offsets: acked; reads return 0; writes discarded.
  - Out-of-window: ignored, no ack.
- Write clamp: 0 stores 0 (channel off); 1..MIN_WIDTH_US-1 stores MIN_WIDTH_US; values above MAX_WIDTH_US store MAX_WIDTH_US. Only bus_data_in[15:0] is used; upper bits are ignored.
- Bus FSM, IDLE -> WAIT -> ACK -> IDLE:
  - IDLE: a strobe with a window hit latches addr, data and direction, then goes to WAIT with latency counter=1.
  - bus_write and bus_read asserted together: treated as a write.
  - WAIT: counter increments. When counter==ACK_LATENCY go to ACK. With ACK_LATENCY=1, go to ACK the cycle after the strobe.
  - ACK: bus_ack=1 for exactly one cycle. bus_data_out = read data for a read, 0 for a write. The write commits to the register in this cycle. Then return to IDLE.
  - Strobes arriving in WAIT or ACK are dropped; the master times out.
- Timing: microsecond prescaler counts 0..INPUT_CLOCK_SPEED/1e6-1. us_tick fires at terminal count.
- Frame counter: counts 0..PWM_PERIOD_US-1 on us_tick, then wraps to 0 on the next us_tick.
  - At the wrap, all shadow widths load from the width registers.
  - frame_pulse asserts for 1 cycle.
  - Frame count increments, saturating.
- pwm_out[n] = CTRL.enable && !failsafe && (shadow[n] != 0) && (frame_us < shadow[n]).
  - Outputs are registered: one cycle of latency after the frame counter.
  - A width written mid-frame takes effect at the next frame start only. No runt or stretched pulses.
- Clearing CTRL.enable forces pwm_out low on the next cycle; counters keep running. Setting enable starts output at the next frame start, not mid-frame.
- Reset asserted mid-access: ack is aborted and no register is written.

Optional Feature:
FCL_SERVO_FAILSAFE_EN
- Defined:
  - A frame watchdog counts frame starts since the last committed write to any WIDTHn.
  - When it reaches FAILSAFE_FRAMES, failsafe sets: all pwm_out forced low and STATUS[16]=1.
  - The next WIDTHn write clears failsafe and the watchdog. Outputs resume at the following frame start.
  - Writes to CTRL do not feed the watchdog.
- Undefined: no watchdog logic; STATUS[16] reads 0; outputs run indefinitely.

Test Plan:
- Write 0x1010 data 1500, CTRL=1 -> bus_ack exactly 2 cycles after the strobe. Read 0x1010 returns 32'd1500 in the ack cycle and 0 otherwise. pwm_out[0] high for 1500 us of every 20000 us frame.
- Write widths 100, 3000 and 0 to channels 1, 2 and 3 -> reads return 500, 2500 and 0. pwm_out[3] stays low.
- Change WIDTH0 from 1000 to 2000 at frame_us=1500 -> the current pulse ends at 1000 us; the next frame pulse is 2000 us.
- Strobe to 0x2000, and a second strobe one cycle after an accepted one -> no bus_ack for either; no register changes.
- Simultaneous bus_read+bus_write to 0x1000 with data 1 -> treated as a write; CTRL=1; bus_data_out=0 during ack.
- With FCL_SERVO_FAILSAFE_EN, FAILSAFE_FRAMES=3 and no width writes -> after the 3rd frame_pulse, pwm_out=0 and STATUS[16]=1. A write to WIDTH0 clears STATUS[16]; pulses resume at the next frame.

Source files
------------

// File: rtl/fcl_servo_pwm_slave.sv
// rtl/fcl_servo_pwm_slave.sv - strobe/ack bus slave driving per-channel 50 Hz servo PWM
// Optional frame watchdog (forces outputs low) is built when FCL_SERVO_FAILSAFE_EN is defined.
`timescale 1ns/1ps
module fcl_servo_pwm_slave #(
  parameter int          INPUT_CLOCK_SPEED = 50000000,
  parameter int          NUM_CHANNELS      = 8,
  parameter logic [31:0] BASE_ADDR         = 32'h0000_1000,
  parameter int          PWM_PERIOD_US     = 20000,
  parameter int          ACK_LATENCY       = 2,
  parameter int          MIN_WIDTH_US      = 500,
  parameter int          MAX_WIDTH_US      = 2500,
  parameter int          FAILSAFE_FRAMES   = 50
) (
  input  logic                    sys_clk,
  input  logic                    _reset,
  input  logic [31:0]             bus_addr_in,
  input  logic [31:0]             bus_data_in,
  input  logic                    bus_read,
  input  logic                    bus_write,
  output logic [31:0]             bus_data_out,
  output logic                    bus_ack,
  output logic [NUM_CHANNELS-1:0] pwm_out,
  output logic                    frame_pulse
);
  localparam int DIV = INPUT_CLOCK_SPEED / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW  = (PWM_PERIOD_US > 1) ? $clog2(PWM_PERIOD_US) : 1;
  localparam int CW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(PWM_PERIOD_US - 1);
  localparam logic [15:0]   MIN_W      = 16'(MIN_WIDTH_US);
  localparam logic [15:0]   MAX_W      = 16'(MAX_WIDTH_US);
  localparam logic [3:0]    LAT_LAST   = 4'(ACK_LATENCY - 1);

  if (DIV < 1 || (INPUT_CLOCK_SPEED % 1000000) != 0 || NUM_CHANNELS < 1 || NUM_CHANNELS > 16 ||
      ACK_LATENCY < 1 || ACK_LATENCY > 15 || FAILSAFE_FRAMES < 1) begin : g_param_check
    $error("fcl_servo_pwm_slave: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t state, state_nxt;

  logic [3:0]    lat_cnt;
  logic [7:0]    req_off;
  logic [15:0]   req_data;
  logic          req_wr;
  logic          accept, commit;
  logic          sel_ctrl, sel_status, sel_width;
  logic [CW-1:0] ch_sel;
  logic [31:0]   rdata;
  logic          unused_data_hi;

  logic          ctrl_en, run, failsafe;
  logic [15:0]   width_q  [NUM_CHANNELS];
  logic [15:0]   shadow_q [NUM_CHANNELS];
  logic [PW-1:0] presc;
  logic [FW-1:0] frame_us;
  logic [15:0]   frame_cnt;
  logic          us_tick, frame_start;

  function automatic logic [15:0] clamp_width(input logic [15:0] v);
    if (v == 16'd0)  return 16'd0;
    if (v < MIN_W)   return MIN_W;
    if (v > MAX_W)   return MAX_W;
    return v;
  endfunction

  assign unused_data_hi = ^bus_data_in[31:16];
  assign accept = (state == S_IDLE) && (bus_read || bus_write) && (bus_addr_in[31:8] == BASE_ADDR[31:8]);
  assign commit = (state == S_ACK) && req_wr;

  assign sel_ctrl   = req_off == 8'h00;
  assign sel_status = req_off == 8'h04;
  assign sel_width  = (req_off[1:0] == 2'b00) && (req_off[7:2] >= 6'd4) && (req_off[7:2] < 6'(4 + NUM_CHANNELS));
  assign ch_sel     = CW'(req_off[7:2] - 6'd4);

  always_ff @(posedge sys_clk or negedge _reset) begin
    if (!_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (ACK_LATENCY == 1) ? S_ACK : S_WAIT;
      S_WAIT:  if (lat_cnt == LAT_LAST) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_ack      = state == S_ACK;
    bus_data_out = (state == S_ACK && !req_wr) ? rdata : 32'd0;
  end

  // A simultaneous read+write strobe is recorded as a write.
  always_ff @(posedge sys_clk or negedge _reset) begin
    if (!_reset) begin
      lat_cnt  <= 4'd0;
      req_off  <= 8'd0;
      req_data <= 16'd0;
      req_wr   <= 1'b0;
    end else if (accept) begin
      lat_cnt  <= 4'd1;
      req_off  <= bus_addr_in[7:0];
      req_data <= bus_data_in[15:0];
      req_wr   <= bus_write;
    end else if (state == S_WAIT) begin
      lat_cnt  <= lat_cnt + 4'd1;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel_ctrl)        rdata[0]    = ctrl_en;
    else if (sel_status) rdata       = {15'd0, failsafe, frame_cnt};
    else if (sel_width)  rdata[15:0] = width_q[ch_sel];
  end

  always_ff @(posedge sys_clk or negedge _reset) begin
    if (!_reset) begin
      ctrl_en <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) width_q[i] <= 16'd0;
    end else if (commit) begin
      if (sel_ctrl)  ctrl_en         <= req_data[0];
      if (sel_width) width_q[ch_sel] <= clamp_width(req_data);
    end
  end

  assign us_tick     = presc == PRESC_LAST;
  assign frame_start = us_tick && (frame_us == FRAME_LAST);

  always_ff @(posedge sys_clk or negedge _reset) begin
    if (!_reset) begin
      presc       <= '0;
      frame_us    <= '0;
      frame_cnt   <= 16'd0;
      frame_pulse <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) shadow_q[i] <= 16'd0;
    end else begin
      presc       <= us_tick ? '0 : presc + 1'b1;
      frame_pulse <= frame_start;
      if (us_tick) frame_us <= frame_start ? '0 : frame_us + 1'b1;
      if (frame_start) begin
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
        for (int i = 0; i < NUM_CHANNELS; i++) shadow_q[i] <= width_q[i];
      end
    end
  end

`ifdef FCL_SERVO_FAILSAFE_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge sys_clk or negedge _reset) begin
    if (!_reset) begin
      wd_cnt   <= 16'd0;
      failsafe <= 1'b0;
    end else if (commit && sel_width) begin
      wd_cnt   <= 16'd0;
      failsafe <= 1'b0;
    end else if (frame_start && !failsafe) begin
      wd_cnt <= wd_cnt + 16'd1;
      if (wd_cnt + 16'd1 == 16'(FAILSAFE_FRAMES)) failsafe <= 1'b1;
    end
  end
`else
  assign failsafe = 1'b0;
`endif

  // Output only runs from a frame start onward, so enabling or leaving failsafe never yields a runt pulse.
  always_ff @(posedge sys_clk or negedge _reset) begin
    if (!_reset)                 run <= 1'b0;
    else if (!ctrl_en || failsafe) run <= 1'b0;
    else if (frame_start)        run <= 1'b1;
  end

  always_ff @(posedge sys_clk or negedge _reset) begin
    if (!_reset) begin
      pwm_out <= '0;
    end else begin
      for (int n = 0; n < NUM_CHANNELS; n++)
        pwm_out[n] <= run && ctrl_en && !failsafe && (shadow_q[n] != 16'd0) &&
                      (16'(frame_us) < shadow_q[n]);
    end
  end
endmodule

// File: tb/tb_fcl_servo_pwm_slave.sv
// tb/tb_fcl_servo_pwm_slave.sv - scoreboard bench for fcl_servo_pwm_slave
// Scaled timing: 2 clocks per us, 200 us frame, widths clamped to 5..150 us.
`timescale 1ns/1ps
module tb_fcl_servo_pwm_slave;
  localparam int DIV       = 2;
  localparam int NCH       = 4;
  localparam int PERIOD    = 200;
  localparam int ACK_LAT   = 2;
  localparam int FRAME_CYC = PERIOD * DIV;
  localparam logic [31:0] A_CTRL = 32'h0000_1000;
  localparam logic [31:0] A_STAT = 32'h0000_1004;
  localparam logic [31:0] A_W0   = 32'h0000_1010;
`ifdef FCL_SERVO_FAILSAFE_EN
  localparam bit FS_EN = 1'b1;
`else
  localparam bit FS_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [31:0]    bus_addr = 32'd0, bus_wdata = 32'd0;
  logic           bus_read = 1'b0, bus_write = 1'b0;
  logic [31:0]    bus_rdata;
  logic           bus_ack;
  logic [NCH-1:0] pwm_out;
  logic           frame_pulse;

  int n_chk = 0, n_err = 0, cyc = 0, nframes = 0;
  int hi [NCH];

  typedef struct { logic [31:0] data; int cyc; } sb_t;
  sb_t sb [$];

  fcl_servo_pwm_slave #(
    .INPUT_CLOCK_SPEED(DIV * 1000000), .NUM_CHANNELS(NCH), .BASE_ADDR(32'h0000_1000),
    .PWM_PERIOD_US(PERIOD), .ACK_LATENCY(ACK_LAT), .MIN_WIDTH_US(5), .MAX_WIDTH_US(150),
    .FAILSAFE_FRAMES(3)
  ) dut (
    .sys_clk(clk), ._reset(rst_n), .bus_addr_in(bus_addr), .bus_data_in(bus_wdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_data_out(bus_rdata), .bus_ack(bus_ack),
    .pwm_out(pwm_out), .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (frame_pulse) nframes++;
    if (bus_ack) begin
      if (sb.size() == 0) check_eq("spurious_ack", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check_eq("ack_data", bus_rdata, e.data);
        check_eq("ack_latency", cyc - e.cyc, ACK_LAT);
      end
    end else if (bus_rdata != 32'd0) begin
      check_eq("data_outside_ack", bus_rdata, 32'd0);
    end
  end

  task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp, input bit acked);
    @(negedge clk);
    if (acked) sb.push_back('{exp, cyc});
    bus_read = rd; bus_write = wr; bus_addr = addr; bus_wdata = data;
    @(negedge clk);
    bus_read = 1'b0; bus_write = 1'b0;
    repeat (ACK_LAT + 1) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_xfer(1'b0, 1'b1, a, d, 32'd0, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    bus_xfer(1'b1, 1'b0, a, 32'd0, e, 1'b1);
  endtask

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (!frame_pulse && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    if (!frame_pulse) check_eq("frame_timeout", 32'd0, 32'd1);
  endtask

  // Called on a frame_pulse negedge; returns on the next one.
  task automatic measure_frame();
    for (int c = 0; c < NCH; c++) hi[c] = 0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      for (int c = 0; c < NCH; c++) if (pwm_out[c]) hi[c]++;
      @(negedge clk);
    end
    check_eq("frame_period", frame_pulse, 1'b1);
  endtask

  task automatic chk_frame(input string tag, input int w0, input int w1, input int w2, input int w3);
    int w [NCH];
    w = '{w0, w1, w2, w3};
    for (int c = 0; c < NCH; c++) check_eq($sformatf("%s_ch%0d", tag, c), hi[c], w[c] * DIV);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] bnd_in  [6] = '{32'h0001_0003, 32'd4, 32'd5, 32'd150, 32'd151, 32'd3000};
    logic [31:0] bnd_exp [6] = '{32'd5, 32'd5, 32'd5, 32'd150, 32'd150, 32'd150};

    repeat (3) begin
      @(negedge clk);
      check_eq("rst_pwm", pwm_out, '0);
      check_eq("rst_ack", bus_ack, 1'b0);
      check_eq("rst_frame_pulse", frame_pulse, 1'b0);
    end
    rst_n = 1'b1;
    rd(A_CTRL, 32'd0);
    rd(A_STAT, 32'd0);
    rd(A_W0, 32'd0);

    wr(A_W0, 32'd100);
    wr(A_CTRL, 32'd1);
    rd(A_W0, 32'd100);
    rd(A_CTRL, 32'd1);

    for (int i = 0; i < 6; i++) begin
      wr(A_W0 + 32'd12, bnd_in[i]);
      rd(A_W0 + 32'd12, bnd_exp[i]);
    end
    wr(A_W0 + 32'd4,  32'hFFFF_0003);
    wr(A_W0 + 32'd8,  32'd3000);
    wr(A_W0 + 32'd12, 32'hABCD_0000);
    rd(A_W0 + 32'd4,  32'd5);
    rd(A_W0 + 32'd8,  32'd150);
    rd(A_W0 + 32'd12, 32'd0);

    wait_frame();
    measure_frame();
    chk_frame("base", 100, 5, 150, 0);
    @(negedge clk);
    rd(A_STAT, {16'd0, nframes[15:0]});

    // Width changes mid-frame, after and during the active pulse.
    wr(A_W0, 32'd40);
    wait_frame();
    fork
      measure_frame();
      begin repeat (120) @(negedge clk); wr(A_W0, 32'd80); end
    join
    chk_frame("late_grow", 40, 5, 150, 0);
    fork
      measure_frame();
      begin repeat (60) @(negedge clk); wr(A_W0, 32'd20); end
    join
    chk_frame("in_pulse_shrink", 80, 5, 150, 0);
    measure_frame();
    chk_frame("shrunk", 20, 5, 150, 0);

    // Second strobe while busy is dropped.
    @(negedge clk);
    sb.push_back('{32'd0, cyc});
    bus_write = 1'b1; bus_addr = A_W0; bus_wdata = 32'd30;
    @(negedge clk);
    bus_addr = A_W0 + 32'd4; bus_wdata = 32'd99;
    @(negedge clk);
    bus_write = 1'b0;
    repeat (4) @(negedge clk);
    rd(A_W0, 32'd30);
    rd(A_W0 + 32'd4, 32'd5);

    wr(32'h0000_1080, 32'd1);
    rd(32'h0000_1008, 32'd0);
    rd(32'h0000_1020, 32'd0);
    rd(32'h0000_1011, 32'd0);
    bus_xfer(1'b0, 1'b1, 32'h0000_2000, 32'd1, 32'd0, 1'b0);
    bus_xfer(1'b0, 1'b1, 32'h0000_2010, 32'd7, 32'd0, 1'b0);
    bus_xfer(1'b1, 1'b0, 32'h0000_1100, 32'd0, 32'd0, 1'b0);
    rd(A_W0, 32'd30);
    rd(A_CTRL, 32'd1);

    // Disable forces low at once; re-enable waits for the next frame.
    wr(A_W0 + 32'd12, 32'd0);
    wait_frame();
    repeat (20) @(negedge clk);
    check_eq("pre_disable_ch2", pwm_out[2], 1'b1);
    wr(A_CTRL, 32'd0);
    check_eq("disable_low", pwm_out, '0);
    wait_frame();
    fork
      measure_frame();
      begin
        repeat (20) @(negedge clk);
        bus_xfer(1'b1, 1'b1, A_CTRL, 32'd1, 32'd0, 1'b1);
        rd(A_CTRL, 32'd1);
        wr(A_W0 + 32'd12, 32'd0);
      end
    join
    chk_frame("enable_mid", 0, 0, 0, 0);
    measure_frame();
    chk_frame("reenabled", 30, 5, 150, 0);

    wait_frame();
    @(negedge clk);
    rd(A_STAT, {15'd0, FS_EN, nframes[15:0]});
    wait_frame();
    measure_frame();
    if (FS_EN) chk_frame("failsafe", 0, 0, 0, 0);
    else       chk_frame("no_failsafe", 30, 5, 150, 0);
    wr(A_W0, 32'd20);
    rd(A_STAT, {16'd0, nframes[15:0]});
`ifdef FCL_SERVO_FAILSAFE_EN
    check_eq("fs_hold_low", pwm_out, '0);
`endif
    wait_frame();
    measure_frame();
    chk_frame("resumed", 20, 5, 150, 0);

    // Reset during WAIT aborts the access.
    @(negedge clk);
    bus_write = 1'b1; bus_addr = A_W0 + 32'd4; bus_wdata = 32'd77;
    @(negedge clk);
    bus_write = 1'b0; rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_ack", bus_ack, 1'b0);
      check_eq("midrst_pwm", pwm_out, '0);
    end
    rst_n = 1'b1;
    rd(A_W0 + 32'd4, 32'd0);
    rd(A_CTRL, 32'd0);
    rd(A_STAT, 32'd0);

    repeat (5) @(negedge clk);
    check_eq("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
